// File: rtl/ring_pkg.sv
// ---------------------------------------------------------------------------
// ring_pkg
// Definitions shared by the bidirectional-ring router and its network
// interface (ring_nic).
//   - Data and register-address widths.
//   - Register addresses in the NIC's processor window.
//   - Bit positions of the packet fields.
//   - Channel indices used by the NIC's buffer array.
// ---------------------------------------------------------------------------
package ring_pkg;

    localparam int RING_DATA_WIDTH = 64;
    localparam int RING_ADDR_WIDTH = 2;

    // Processor register window
    localparam logic [1:0] ADDR_IN_BUF     = 2'd0;
    localparam logic [1:0] ADDR_IN_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_OUT_BUF    = 2'd2;
    localparam logic [1:0] ADDR_OUT_STATUS = 2'd3;

    // Packet layout
    localparam int VC_BIT      = 63;   // 0 = even virtual channel, 1 = odd
    localparam int DIR_BIT     = 62;
    localparam int HOP_MSB     = 55;
    localparam int HOP_LSB     = 48;
    localparam int SRC_MSB     = 47;
    localparam int SRC_LSB     = 32;
    localparam int PAYLOAD_MSB = 31;
    localparam int PAYLOAD_LSB = 0;

    // NIC channel buffer indices
    localparam int NUM_CHAN = 2;
    localparam int CH_IN    = 0;
    localparam int CH_OUT   = 1;

    // Buffer occupancy, for readability where a state name helps
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/nic_chan_buf.sv
// ---------------------------------------------------------------------------
// nic_chan_buf
// One packet-wide register plus an occupancy flag. This is a two-state
// EMPTY/FULL controller.
//   clk    in   system clock
//   reset  in   synchronous active-high reset; clears the data and the flag
//   load   in   capture d and mark the buffer full
//   clear  in   mark the buffer empty; the data is kept
//   d      in   WIDTH  data to capture
//   q      out  WIDTH  stored data
//   full   out  occupancy flag
// If load and clear are both asserted, load wins. A packet that arrives in
// the same cycle as a clear is therefore never lost.
// ---------------------------------------------------------------------------
module nic_chan_buf
    import ring_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    buf_state_e       state_reg;
    buf_state_e       state_next;

    always_comb begin
        data_next  = data_reg;
        state_next = state_reg;
        if (load) begin
            data_next  = d;
            state_next = BUF_FULL;
        end else if (clear) begin
            state_next = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg  <= '0;
            state_reg <= BUF_EMPTY;
        end else begin
            data_reg  <= data_next;
            state_reg <= state_next;
        end
    end

    assign q    = data_reg;
    assign full = (state_reg == BUF_FULL);

endmodule

// File: rtl/ring_nic.sv
// ---------------------------------------------------------------------------
// ring_nic
// Network interface between a processor and the PE port of a
// bidirectional-ring router.
//
// Processor side:
//   addr     in   ADDR_WIDTH  register select
//                             0 = in_buf, 1 = in_status,
//                             2 = out_buf, 3 = out_status
//   d_in     in   DATA_WIDTH  write data
//   d_out    out  DATA_WIDTH  read data (combinational)
//   nicEn    in   access enable
//   nicWrEn  in   1 = write, 0 = read
//
// Router side, toward the router's PE input:
//   net_so        out  send strobe
//   net_ro        in   router ready
//   net_do        out  DATA_WIDTH packet
//   net_polarity  in   0 = even cycle, 1 = odd cycle
//
// Router side, from the router's PE output:
//   net_si   in   send strobe
//   net_ri   out  NIC ready (~in_full)
//   net_di   in   DATA_WIDTH packet
//
// Buffers:
//   - The output buffer is loaded by a processor write to out_buf. It is
//     drained when the router accepts the packet on a cycle whose polarity
//     matches the packet's VC bit.
//   - The input buffer is loaded from the router. It is drained by a
//     processor read of in_buf (read-to-clear).
// ---------------------------------------------------------------------------
module ring_nic
    import ring_pkg::*;
#(
    parameter int DATA_WIDTH = RING_DATA_WIDTH,
    parameter int ADDR_WIDTH = RING_ADDR_WIDTH,
    parameter int VC_BIT     = ring_pkg::VC_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    // processor register window
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    // injection toward the router
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity,
    // ejection from the router
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di
);

    logic [NUM_CHAN-1:0]   chan_load;
    logic [NUM_CHAN-1:0]   chan_clear;
    logic [NUM_CHAN-1:0]   chan_full;
    logic [DATA_WIDTH-1:0] chan_d [NUM_CHAN];
    logic [DATA_WIDTH-1:0] chan_q [NUM_CHAN];

    logic rd_en;
    logic wr_en;
    logic in_full;
    logic out_full;
    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;

    assign rd_en    = nicEn & ~nicWrEn;
    assign wr_en    = nicEn & nicWrEn;
    assign in_full  = chan_full[CH_IN];
    assign out_full = chan_full[CH_OUT];
    assign in_buf   = chan_q[CH_IN];
    assign out_buf  = chan_q[CH_OUT];

    // ---------------- channel buffers ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            nic_chan_buf #(
                .WIDTH (DATA_WIDTH)
            ) u_buf (
                .clk   (clk),
                .reset (reset),
                .load  (chan_load[gi]),
                .clear (chan_clear[gi]),
                .d     (chan_d[gi]),
                .q     (chan_q[gi]),
                .full  (chan_full[gi])
            );
        end
    endgenerate

    // ---------------- injection ----------------
    // A packet may only leave on the cycle that belongs to its own virtual
    // channel. This keeps even and odd traffic on separate router slots.
    assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
    assign net_do = net_so ? out_buf : '0;

    // A write that arrives while the buffer is full is dropped. This
    // includes the cycle in which the packet is leaving: a new write is
    // accepted only from the next cycle.
    assign chan_load[CH_OUT]  = wr_en & (addr == ADDR_WIDTH'(ADDR_OUT_BUF)) & ~out_full;
    assign chan_clear[CH_OUT] = net_so;
    assign chan_d[CH_OUT]     = d_in;

    // ---------------- ejection ----------------
    // Capture is gated by net_ri. A strobe from the router while the buffer
    // is full is a protocol violation and leaves in_buf untouched.
    assign net_ri            = ~in_full;
    assign chan_load[CH_IN]  = net_si & ~in_full;
    assign chan_clear[CH_IN] = rd_en & (addr == ADDR_WIDTH'(ADDR_IN_BUF));
    assign chan_d[CH_IN]     = net_di;

    // ---------------- processor read mux ----------------
    always_comb begin
        d_out = '0;
        if (rd_en) begin
            case (addr)
                ADDR_WIDTH'(ADDR_IN_BUF):     d_out = in_buf;
                ADDR_WIDTH'(ADDR_IN_STATUS):  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_WIDTH'(ADDR_OUT_STATUS): d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:                      d_out = '0;  // out_buf is write-only
            endcase
        end
    end

endmodule
